// File: rtl/heap_arbiter.sv
// Arbitrates NREQ requesters onto one external max-heap and delivers popped
// entries highest-key-first through a one-entry output register.
`timescale 1ns/1ps

module heap_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DW    = 8,
    parameter int PW    = DW - IDW,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*PW-1:0] req_prio,
    output logic [NREQ-1:0]   req_ready,
    output logic              deq_valid,
    output logic [PW-1:0]     deq_prio,
    output logic [IDW-1:0]    deq_id,
    input  logic              deq_ready,
    output logic              hp_push,
    output logic              hp_pop,
    output logic [DW-1:0]     hp_din,
    input  logic [DW-1:0]     hp_dout,
    input  logic              hp_idle,
    output logic [4:0]        count,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAPT = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic           last_pop;

    logic           issue_en;
    logic           out_free;
    logic           push_ok;
    logic           pop_ok;
    logic           do_push;
    logic           do_pop;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [PW-1:0]  grant_prio;

    // NOTE: strobes are combinational, so they are also gated by rst_n to hold
    // every output at 0 while reset is asserted, not just after the next edge.
    assign issue_en = rst_n && (state == S_IDLE);
    assign out_free = !deq_valid || deq_ready;
    assign push_ok  = issue_en && (req_valid != '0) && (count < DEPTH_C) && hp_idle;
    assign pop_ok   = issue_en && (count != 5'd0) && out_free && hp_idle;

    // When both are eligible, alternate: pop unless the last issued op was a pop.
    assign do_pop   = pop_ok && (!push_ok || !last_pop);
    assign do_push  = push_ok && !do_pop;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign grant_prio = req_prio[grant_idx*PW +: PW];

    assign hp_push   = do_push;
    assign hp_pop    = do_pop;
    assign hp_din    = do_push ? {grant_prio, grant_idx} : '0;
    assign req_ready = do_push ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign busy      = (state != S_IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            rr_ptr    <= '0;
            last_pop  <= 1'b0;
            deq_valid <= 1'b0;
            deq_prio  <= '0;
            deq_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (do_push)     state <= S_WAIT;
                    else if (do_pop) state <= S_CAPT;
                end
                S_CAPT:  state <= S_WAIT;
                S_WAIT:  if (hp_idle) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (do_push) begin
                count    <= count + 5'd1;
                rr_ptr   <= grant_idx + IDW'(1);
                last_pop <= 1'b0;
            end else if (do_pop) begin
                count    <= count - 5'd1;
                last_pop <= 1'b1;
            end

            // hp_dout is valid in the cycle after hp_pop, which is exactly CAPT.
            if (state == S_CAPT) begin
                deq_valid          <= 1'b1;
                {deq_prio, deq_id} <= hp_dout;
            end else if (deq_valid && deq_ready) begin
                deq_valid <= 1'b0;
            end
        end
    end

endmodule
